// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 LCD controller.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_ROW1     = 8'h80;
  localparam logic [7:0] CMD_ROW2     = 8'hC0;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_ADDR1,
    ST_ROW1,
    ST_ADDR2,
    ST_ROW2
  } top_state_t;

  typedef enum logic [2:0] {
    XF_IDLE,
    XF_SETUP1,
    XF_SETUP2,
    XF_PULSE,
    XF_WAIT
  } xfer_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  // Nibble values become their ASCII hex digit; anything else is already a glyph code.
  function automatic logic [7:0] char_conv(input logic [7:0] v);
    if (v < 8'h0A)      return 8'h30 + v;
    else if (v < 8'h10) return 8'h41 + (v - 8'h0A);
    else                return v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// One HD44780 bus transfer: SETUP (2 cycles), PULSE (EN_CYCLES, EN high), WAIT (wait_cycles).
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES = 16,
  parameter int CNT_W     = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rs,
  input  logic [7:0]       data,
  input  logic [CNT_W-1:0] wait_cycles,
  output logic             busy,
  output logic             done,
  output logic             lcd_en,
  output logic             lcd_rs,
  output logic [7:0]       lcd_data,
  output xfer_state_t      dbg_state
);

  // Handshake: start is taken on any cycle busy is low. done pulses on the
  // final WAIT cycle, where busy is already low, so a chained start begins
  // the next SETUP on the very next cycle with no gap.
  xfer_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             accept;

  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(EN_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      XF_IDLE:   ;
      XF_SETUP1: state_d = XF_SETUP2;
      XF_SETUP2: begin
        state_d = XF_PULSE;
        cnt_d   = '0;
      end
      XF_PULSE: begin
        if (cnt_q == EN_LAST) begin
          cnt_d = '0;
          if (wait_q == '0) begin
            done    = 1'b1;
            state_d = XF_IDLE;
          end else begin
            state_d = XF_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XF_WAIT: begin
        if (cnt_q == wait_q - CNT_W'(1)) begin
          done    = 1'b1;
          state_d = XF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = XF_IDLE;
    endcase
    busy   = (state_q != XF_IDLE) && !done;
    accept = start && !busy;
    if (accept) begin
      state_d = XF_SETUP1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= XF_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rs_q   <= rs;
        wait_q <= wait_cycles;
      end
      // The source index settles at SETUP entry, so the byte is sampled here.
      if (state_q == XF_SETUP1) data_q <= data;
    end
  end

  assign lcd_en    = (state_q == XF_PULSE);
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/lcd_controller.sv
// HD44780 16x2 controller: power-up wait, init commands, then endless two-row refresh.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES    = 1_000_000,
  parameter int EN_CYCLES         = 16,
  parameter int CMD_WAIT_CYCLES   = 2_500,
  parameter int CLEAR_WAIT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  lcd_index,
  input  logic [7:0]  lcd_char,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_EN,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_ON,
  output logic        LCD_BLON,
  output logic        init_done,
  output logic        frame_done,
  output top_state_t  dbg_state,
  output xfer_state_t dbg_xfer_state
);

  localparam int CNT_W = $clog2(max3(EN_CYCLES, CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES) + 1);
  localparam int PU_W  = $clog2(POWERUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_CMD   = CNT_W'(CMD_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_CLEAR = CNT_W'(CLEAR_WAIT_CYCLES);
  localparam logic [PU_W-1:0]  PU_LAST    = PU_W'(POWERUP_CYCLES - 1);

  top_state_t       state_q, state_d;
  logic [PU_W-1:0]  pu_cnt_q, pu_cnt_d;
  logic [1:0]       step_q, step_d;
  logic [4:0]       index_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             start, nxt_rs;
  logic [CNT_W-1:0] nxt_wait;
  logic             set_init, set_frame;
  logic             xfer_busy, xfer_done;
  logic [7:0]       xfer_data;

  // Every transfer is launched in the done cycle of the previous one, so the
  // bus never idles between transfers once POWERUP has finished.
  always_comb begin
    state_d   = state_q;
    pu_cnt_d  = pu_cnt_q;
    step_d    = step_q;
    index_d   = lcd_index;
    cmd_d     = cmd_q;
    start     = 1'b0;
    nxt_rs    = 1'b0;
    nxt_wait  = WAIT_CMD;
    set_init  = 1'b0;
    set_frame = 1'b0;
    case (state_q)
      ST_POWERUP: begin
        if (pu_cnt_q == PU_LAST) begin
          state_d = ST_INIT;
          step_d  = 2'd0;
          cmd_d   = init_cmd(2'd0);
          start   = 1'b1;
        end else begin
          pu_cnt_d = pu_cnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (xfer_done) begin
          start = 1'b1;
          if (step_q == 2'd3) begin
            state_d  = ST_ADDR1;
            cmd_d    = CMD_ROW1;
            index_d  = 5'd0;
            set_init = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
            cmd_d  = init_cmd(step_q + 2'd1);
            if (init_cmd(step_q + 2'd1) == CMD_CLEAR) nxt_wait = WAIT_CLEAR;
          end
        end
      end
      ST_ADDR1: begin
        if (xfer_done) begin
          state_d = ST_ROW1;
          start   = 1'b1;
          nxt_rs  = 1'b1;
          index_d = 5'd0;
        end
      end
      ST_ROW1: begin
        if (xfer_done) begin
          start = 1'b1;
          if (lcd_index == 5'd15) begin
            state_d = ST_ADDR2;
            cmd_d   = CMD_ROW2;
          end else begin
            nxt_rs  = 1'b1;
            index_d = lcd_index + 5'd1;
          end
        end
      end
      ST_ADDR2: begin
        if (xfer_done) begin
          state_d = ST_ROW2;
          start   = 1'b1;
          nxt_rs  = 1'b1;
          index_d = 5'd16;
        end
      end
      ST_ROW2: begin
        if (xfer_done) begin
          start = 1'b1;
          if (lcd_index == 5'd31) begin
            state_d   = ST_ADDR1;
            cmd_d     = CMD_ROW1;
            index_d   = 5'd0;
            set_frame = 1'b1;
          end else begin
            nxt_rs  = 1'b1;
            index_d = lcd_index + 5'd1;
          end
        end
      end
      default: state_d = ST_POWERUP;
    endcase
    if (!start || xfer_busy) begin
      start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_POWERUP;
      pu_cnt_q   <= '0;
      step_q     <= 2'd0;
      lcd_index  <= 5'd0;
      cmd_q      <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      pu_cnt_q   <= pu_cnt_d;
      step_q     <= step_d;
      lcd_index  <= index_d;
      cmd_q      <= cmd_d;
      init_done  <= init_done | set_init;
      frame_done <= set_frame;
    end
  end

  assign xfer_data = LCD_RS ? char_conv(lcd_char) : cmd_q;

  lcd_xfer #(
    .EN_CYCLES (EN_CYCLES),
    .CNT_W     (CNT_W)
  ) u_xfer (
    .clk         (clk),
    .rst         (reset),
    .start       (start),
    .rs          (nxt_rs),
    .data        (xfer_data),
    .wait_cycles (nxt_wait),
    .busy        (xfer_busy),
    .done        (xfer_done),
    .lcd_en      (LCD_EN),
    .lcd_rs      (LCD_RS),
    .lcd_data    (LCD_DATA),
    .dbg_state   (dbg_xfer_state)
  );

  assign LCD_RW    = 1'b0;
  assign LCD_ON    = 1'b1;
  assign LCD_BLON  = 1'b1;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller with short timing parameters and a text-source table.
module tb_lcd_controller;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  lcd_index;
  logic [7:0]  lcd_char;
  logic [7:0]  LCD_DATA;
  logic        LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON;
  logic        init_done, frame_done;
  top_state_t  dbg_state;
  xfer_state_t dbg_xfer_state;

  logic [7:0]  text [32];
  logic [13:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  lcd_controller #(
    .POWERUP_CYCLES    (100),
    .EN_CYCLES         (4),
    .CMD_WAIT_CYCLES   (10),
    .CLEAR_WAIT_CYCLES (40)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lcd_index      (lcd_index),
    .lcd_char       (lcd_char),
    .LCD_DATA       (LCD_DATA),
    .LCD_EN         (LCD_EN),
    .LCD_RS         (LCD_RS),
    .LCD_RW         (LCD_RW),
    .LCD_ON         (LCD_ON),
    .LCD_BLON       (LCD_BLON),
    .init_done      (init_done),
    .frame_done     (frame_done),
    .dbg_state      (dbg_state),
    .dbg_xfer_state (dbg_xfer_state)
  );

  // Clock / reset-relative cycle count
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  assign lcd_char = text[lcd_index];

  function automatic logic [7:0] model_conv(input logic [7:0] v);
    string hexd;
    hexd = "0123456789ABCDEF";
    if (v < 16) return hexd[v];
    return v;
  endfunction

  task automatic push_cmd(input logic [7:0] c);
    exp_q.push_back({5'd0, 1'b0, c});
  endtask

  task automatic push_data(input int i);
    exp_q.push_back({5'(i), 1'b1, model_conv(text[i])});
  endtask

  task automatic push_frame();
    push_cmd(8'h80);
    for (int i = 0; i < 16; i++) push_data(i);
    push_cmd(8'hC0);
    for (int i = 16; i < 32; i++) push_data(i);
  endtask

  // Scoreboard / monitor: checks each transfer when EN rises
  logic        prev_en = 1'b0, prev_fd = 1'b0, first_rise = 1'b1;
  logic [13:0] held, e;
  int en_len = 0, last_rise = 0, gap_exp = 16, fd_cyc = -100, fd_count = 0, addr1_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_en    = 1'b0;
      prev_fd    = 1'b0;
      first_rise = 1'b1;
      en_len     = 0;
    end else begin
      if (LCD_EN && !prev_en) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_transfer: got rs=%0b data=%h idx=%0d, required no transfer", LCD_RS, LCD_DATA, lcd_index);
        end else begin
          e = exp_q.pop_front();
          if ({LCD_RS, LCD_DATA} !== e[8:0]) begin
            n_err++;
            $display("FAIL xfer_data: got rs=%0b data=%h, required rs=%0b data=%h", LCD_RS, LCD_DATA, e[8], e[7:0]);
          end
          n_vec++;
          if ($isunknown(lcd_index) || (e[8] && lcd_index !== e[13:9])) begin
            n_err++;
            $display("FAIL xfer_index: got %0d, required %0d", lcd_index, e[13:9]);
          end
          n_vec++;
          if (first_rise) begin
            if (cyc !== 102) begin
              n_err++;
              $display("FAIL first_en_cycle: got %0d, required 102", cyc);
            end
          end else if (cyc - last_rise !== gap_exp) begin
            n_err++;
            $display("FAIL xfer_spacing: got %0d, required %0d (data %h)", cyc - last_rise, gap_exp, e[7:0]);
          end
          gap_exp = (e[8:0] == {1'b0, 8'h01}) ? 46 : 16;
          if (e[8:0] == {1'b0, 8'h06}) begin
            n_vec++;
            if (init_done !== 1'b0) begin
              n_err++;
              $display("FAIL init_done_early: got %b, required 0", init_done);
            end
          end
          if (e[8:0] == {1'b0, 8'h80}) begin
            n_vec++;
            if (init_done !== 1'b1) begin
              n_err++;
              $display("FAIL init_done_level: got %b, required 1", init_done);
            end
            n_vec++;
            if (addr1_seen > 0) begin
              if (fd_cyc !== cyc - 2) begin
                n_err++;
                $display("FAIL frame_done_pos: got cycle %0d, required %0d", fd_cyc, cyc - 2);
              end
            end else if (fd_count !== 0) begin
              n_err++;
              $display("FAIL frame_done_spurious: got %0d pulses, required 0", fd_count);
            end
            addr1_seen++;
          end
        end
        first_rise = 1'b0;
        last_rise  = cyc;
        held       = {lcd_index, LCD_RS, LCD_DATA};
        en_len     = 1;
      end else if (LCD_EN) begin
        en_len++;
        n_vec++;
        if ({lcd_index, LCD_RS, LCD_DATA} !== held) begin
          n_err++;
          $display("FAIL bus_stable: got %h, required %h", {lcd_index, LCD_RS, LCD_DATA}, held);
        end
      end
      if (!LCD_EN && prev_en) begin
        n_vec++;
        if (en_len !== 4) begin
          n_err++;
          $display("FAIL en_width: got %0d, required 4", en_len);
        end
      end
      if (frame_done === 1'b1) begin
        n_vec++;
        if (prev_fd !== 1'b0) begin
          n_err++;
          $display("FAIL frame_done_width: got 2+ cycles, required 1");
        end
        fd_cyc = cyc;
        fd_count++;
      end
      prev_en = LCD_EN;
      prev_fd = frame_done;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({LCD_EN, LCD_RS, LCD_DATA, lcd_index, init_done, frame_done} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b rs=%b data=%h idx=%0d init=%b fd=%b, required all 0",
               LCD_EN, LCD_RS, LCD_DATA, lcd_index, init_done, frame_done);
    end
    n_vec++;
    if ({LCD_RW, LCD_ON, LCD_BLON} !== 3'b011) begin
      n_err++;
      $display("FAIL reset_tieoffs: got rw/on/blon=%b, required 011", {LCD_RW, LCD_ON, LCD_BLON});
    end
  endtask

  task automatic test_init_and_frames();
    int budget;
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h01); push_cmd(8'h06);
    push_frame(); push_frame(); push_frame();
    reset = 1'b0;
    budget = 0;
    while (exp_q.size() > 10 && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    n_vec++;
    if (exp_q.size() > 10) begin
      n_err++;
      $display("FAIL frames_timeout: got %0d pending, required <= 10", exp_q.size());
    end
    n_vec++;
    if (fd_count !== 2) begin
      n_err++;
      $display("FAIL frame_done_count: got %0d, required 2", fd_count);
    end
    n_vec++;
    if ({init_done, LCD_RW, LCD_ON, LCD_BLON} !== 4'b1011) begin
      n_err++;
      $display("FAIL run_levels: got init/rw/on/blon=%b, required 1011", {init_done, LCD_RW, LCD_ON, LCD_BLON});
    end
  endtask

  task automatic test_reset_mid_row2();
    int budget;
    budget = 0;
    while (!(LCD_EN === 1'b1 && lcd_index >= 5'd16) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    n_vec++;
    if (!(LCD_EN === 1'b1 && lcd_index >= 5'd16)) begin
      n_err++;
      $display("FAIL row2_pulse_timeout: got en=%b idx=%0d, required en=1 idx>=16", LCD_EN, lcd_index);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({LCD_EN, lcd_index, init_done, frame_done} !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset: got en=%b idx=%0d init=%b fd=%b, required all 0", LCD_EN, lcd_index, init_done, frame_done);
    end
    n_vec++;
    if ({LCD_RW, LCD_ON, LCD_BLON} !== 3'b011) begin
      n_err++;
      $display("FAIL tieoffs_in_reset: got %b, required 011", {LCD_RW, LCD_ON, LCD_BLON});
    end
    exp_q.delete();
    fd_count   = 0;
    addr1_seen = 0;
    gap_exp    = 16;
    repeat (3) @(negedge clk);
    push_cmd(8'h38); push_cmd(8'h0C);
    reset = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL restart_timeout: got %0d pending, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) text[i] = 8'($urandom_range(0, 255));
    text[0]  = 8'h48;
    text[1]  = 8'h00;
    text[2]  = 8'h0F;
    text[5]  = 8'h0A;
    text[6]  = 8'h07;
    text[20] = 8'h09;
    text[31] = 8'h10;
    test_reset();
    test_init_and_frames();
    test_reset_mid_row2();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 Parameter POWERUP_CYCLES, default 1_000_000, power-on wait before the first command (20 ms at 50 MHz).
REQ-002 Parameter EN_CYCLES, default 16, LCD_EN high time per transfer.
REQ-003 Parameter CMD_WAIT_CYCLES, default 2_500, post-pulse wait for ordinary commands and data (50 us).
REQ-004 Parameter CLEAR_WAIT_CYCLES, default 100_000, post-pulse wait after the clear command (2 ms).
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 lcd_index  output  5  character position requested from the text source; 0-15 is row 1, 16-31 is row 2.
REQ-008 lcd_char  input  8  combinational character returned by the text source for lcd_index.
REQ-009 LCD_DATA  output  8  HD44780 data bus.
REQ-010 LCD_EN  output  1  HD44780 enable strobe.
REQ-011 LCD_RS  output  1  register select: 0 = command, 1 = data.
REQ-012 LCD_RW  output  1  read/write select; tied to 0 (write only).
REQ-013 LCD_ON, LCD_BLON  output  1 each  panel power and backlight; tied to 1.
REQ-014 init_done  output  1  level; high once the init sequence has completed.
REQ-015 frame_done  output  1  one-cycle pulse after the index-31 transfer completes.

Function
REQ-016 Top FSM states: POWERUP -> INIT -> ADDR1 -> ROW1 -> ADDR2 -> ROW2 -> ADDR1, repeating indefinitely.
REQ-017 POWERUP counts POWERUP_CYCLES clocks with LCD_EN=0, then enters INIT.
REQ-018 INIT issues commands in order: 0x38 (function set), 0x0C (display on), 0x01 (clear), 0x06 (entry mode); all RS=0.
REQ-019 The 0x01 transfer waits CLEAR_WAIT_CYCLES; every other transfer waits CMD_WAIT_CYCLES.
REQ-020 init_done rises on the cycle INIT exits to ADDR1 and stays high until reset.
REQ-021 ADDR1 sends command 0x80 and ADDR2 sends command 0xC0, both RS=0.
REQ-022 ROW1 sends data transfers for lcd_index 0..15 and ROW2 for lcd_index 16..31, in order, RS=1.
REQ-023 Each transfer has three phases: SETUP (2 cycles, EN=0), PULSE (EN_CYCLES cycles, EN=1), WAIT (wait-count cycles, EN=0).
REQ-024 LCD_RS, LCD_DATA and lcd_index stay stable from the first SETUP cycle through the last WAIT cycle.
REQ-025 lcd_index updates at entry to SETUP; LCD_DATA is registered at the end of the first SETUP cycle from the converted lcd_char.
REQ-026 Conversion: lcd_char 0x00-0x09 maps to 0x30+v, 0x0A-0x0F maps to 0x41+(v-10), and 0x10-0xFF passes unchanged.
REQ-027 Transfer length = 2 + EN_CYCLES + wait count, exactly, with no idle cycles between consecutive transfers.
REQ-028 frame_done pulses for one cycle on the first cycle of the ADDR1 transfer that follows ROW2.
REQ-029 lcd_index wraps 31 -> 0 only through ADDR1; it never takes a value outside 0-31.
REQ-030 All counters are sized for the largest parameter; a wait count of 0 makes WAIT zero cycles long.

Reset
REQ-031 Reset asserted, asynchronously: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, lcd_index=0, init_done=0, frame_done=0, FSM=POWERUP, all counters 0.
REQ-032 Reset mid-transfer drops LCD_EN within the same cycle (asynchronous clear) and abandons the transfer.
REQ-033 After reset deasserts, the full POWERUP and INIT sequence repeats.
REQ-034 LCD_RW=0, LCD_ON=1 and LCD_BLON=1 hold regardless of reset.

Structure
REQ-035 Shared package lcd_pkg holds the command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0) and the top-state encoding.
REQ-036 One sub-module, lcd_xfer, implements the SETUP/PULSE/WAIT engine: start/busy/done handshake, rs, data and wait-count inputs.
REQ-037 lcd_xfer accepts start only when idle, and pulses done for one cycle at the end of WAIT.

Verification (POWERUP=100, EN=4, CMD_WAIT=10, CLEAR_WAIT=40)
REQ-038 Release reset -> first LCD_EN rise at cycle 102 after release, with LCD_DATA=0x38, RS=0, EN high 4 cycles.
REQ-039 Init sequence -> commands 0x38/0x0C/0x01/0x06 observed with spacing 16/16/46/16 cycles; init_done rises after 0x06 completes.
REQ-040 Source returns 0x0A at index 5 and 0x07 at index 6 -> LCD_DATA 0x41 then 0x37; index 0 returns "H" (0x48) -> 0x48 unchanged.
REQ-041 Full frame -> sequence 0x80, 16 data writes, 0xC0, 16 data writes; frame_done pulses once per frame, one cycle wide.
REQ-042 Assert reset while LCD_EN=1 during ROW2 -> LCD_EN=0 and lcd_index=0 immediately; after release, 0x38 reappears after the POWERUP wait.
REQ-043 Scoreboard checks LCD_DATA and LCD_RS stable whenever LCD_EN=1 and lcd_index always in 0-31.
